uart_tx_framer: RTL and testbench

//  Serial transmitter that produces the frames the team's Rx_path receiver decodes.

---
 rtl/uart_tx_framer.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serial frame transmitter (start, data LSB first, optional even parity, stop)
// with parity/framing error injection. Define TX_HOLD_EN for a one-word holding register.
module uart_tx_framer #(
    parameter int WIDTH_SIZE   = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [WIDTH_SIZE-1:0] input_tx,
    input  logic                  PF,
    input  logic                  err,
    output logic                  ready,
    output logic                  Tx,
    output logic                  done
);
    localparam int BW = $clog2(WIDTH_SIZE + 1);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH_SIZE - 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WIDTH_SIZE-1:0] shift_q, shift_d;
    logic [WIDTH_SIZE-1:0] shift_nxt;
    logic                  pf_q, pf_d;
    logic                  par_q, par_d;
    logic                  stop_q, stop_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;

    logic                  bit_end;
    logic                  accept;
    logic                  load;
    logic [WIDTH_SIZE-1:0] ld_data;
    logic                  ld_pf;
    logic                  ld_err;

`ifdef TX_HOLD_EN
    logic                  hold_full_q, hold_full_d;
    logic [WIDTH_SIZE-1:0] hold_data_q, hold_data_d;
    logic                  hold_pf_q, hold_pf_d;
    logic                  hold_err_q, hold_err_d;

    assign ready = ~hold_full_q;
`else
    assign ready = (state_q == IDLE);
`endif

    assign accept    = valid & ready;
    assign bit_end   = (clk_cnt_q == CLK_LAST);
    assign shift_nxt = shift_q >> 1;
    assign Tx        = tx_q;
    assign done      = done_q;

    // Next-state logic: bit timing, serialisation and frame (re)loading.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pf_d      = pf_q;
        par_d     = par_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        load      = 1'b0;
        ld_data   = input_tx;
        ld_pf     = PF;
        ld_err    = err;
`ifdef TX_HOLD_EN
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_pf_d   = hold_pf_q;
        hold_err_d  = hold_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    clk_cnt_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (pf_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = stop_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = shift_nxt;
                        tx_d      = shift_nxt[0];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    clk_cnt_d = '0;
                    tx_d      = stop_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d    = 1'b1;
                    clk_cnt_d = '0;
`ifdef TX_HOLD_EN
                    if (hold_full_q) begin
                        load        = 1'b1;
                        ld_data     = hold_data_q;
                        ld_pf       = hold_pf_q;
                        ld_err      = hold_err_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
`else
                    state_d = IDLE;
                    tx_d    = 1'b1;
`endif
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
`ifdef TX_HOLD_EN
        // A word accepted while a frame is running waits in the hold register,
        // except on the STOP-end edge where it starts directly.
        if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
            hold_full_d = 1'b1;
            hold_data_d = input_tx;
            hold_pf_d   = PF;
            hold_err_d  = err;
        end
`endif
        if (load) begin
            state_d   = START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = ld_data;
            pf_d      = ld_pf;
            par_d     = (^ld_data) ^ (ld_err & ld_pf);
            stop_d    = ~(ld_err & ~ld_pf);
            tx_d      = 1'b0;
        end
    end

    // State, counters and registered line outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pf_q      <= 1'b0;
            par_q     <= 1'b0;
            stop_q    <= 1'b1;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pf_q      <= pf_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

`ifdef TX_HOLD_EN
    // Holding register for the next word while a frame is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_pf_q   <= 1'b0;
            hold_err_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_pf_q   <= hold_pf_d;
            hold_err_q  <= hold_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: randomized and directed stimulus checked cycle by cycle against
// a queue of expected line samples built from the frame format.
module tb_uart_tx_framer;
    localparam int W   = 16;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_r;
    logic [W-1:0] data_r;
    logic         pf_r;
    logic         err_r;
    logic         ready;
    logic         Tx;
    logic         done;

    typedef struct packed {
        logic tx;
        logic first;
        logic last;
    } smp_t;

    smp_t q[$];
    logic ready_m;
    logic done_m;
    logic acc;
    int   n_chk = 0;
    int   n_err = 0;

    uart_tx_framer #(
        .WIDTH_SIZE  (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .valid   (valid_r),
        .input_tx(data_r),
        .PF      (pf_r),
        .err     (err_r),
        .ready   (ready),
        .Tx      (Tx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line: start 0, data LSB first, optional even parity, stop 1.
    task automatic push_frame(input logic [W-1:0] d, input logic pf, input logic e);
        logic b[$];
        smp_t s;
        b.push_back(1'b0);
        for (int i = 0; i < W; i++) b.push_back(d[i]);
        if (pf) b.push_back((^d) ^ e);
        b.push_back(pf ? 1'b1 : ~e);
        for (int i = 0; i < b.size(); i++) begin
            for (int c = 0; c < CPB; c++) begin
                s.tx    = b[i];
                s.first = (i == 0) && (c == 0);
                s.last  = (i == b.size() - 1) && (c == CPB - 1);
                q.push_back(s);
            end
        end
    endtask

    task automatic step();
        smp_t e;
        logic popped;
        @(posedge clk);
        if (valid_r && ready_m) begin
            push_frame(data_r, pf_r, err_r);
            acc = 1'b1;
        end
        #1;
        chk("done", done, done_m);
        done_m = 1'b0;
        popped = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("tx", Tx, e.tx);
            done_m = e.last;
            popped = 1'b1;
        end else begin
            chk("tx_idle", Tx, 1'b1);
        end
`ifdef TX_HOLD_EN
        ready_m = 1'b1;
        foreach (q[i]) if (q[i].first) ready_m = 1'b0;
`else
        ready_m = ~popped;
`endif
        chk("ready", ready, ready_m);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic pf, input logic e,
                             input int tail);
        int t;
        valid_r = 1'b1;
        data_r  = d;
        pf_r    = pf;
        err_r   = e;
        acc     = 1'b0;
        t       = 0;
        while (!acc && t < 300) begin
            step();
            t++;
        end
        if (!acc) chk("accept_timeout", 1'b0, 1'b1);
        valid_r = 1'b0;
        data_r  = W'($urandom);
        pf_r    = ~pf;
        err_r   = ~e;
        repeat (tail) step();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_tx", Tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        q.delete();
        done_m  = 1'b0;
        ready_m = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_r = 1'b0;
        data_r  = '0;
        pf_r    = 1'b0;
        err_r   = 1'b0;
        ready_m = 1'b1;
        done_m  = 1'b0;
        acc     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_tx", Tx, 1'b1);
        chk("reset_ready", ready, 1'b1);
        chk("reset_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();

        send_word(16'h5555, 1'b0, 1'b0, 80);
        send_word(16'h0001, 1'b1, 1'b0, 80);
        send_word(16'h0001, 1'b1, 1'b1, 80);
        send_word(16'h0001, 1'b0, 1'b1, 80);

        send_word(16'hC3E1, 1'b1, 1'b0, 29);
        reset_mid();
        send_word(16'h1234, 1'b0, 1'b0, 80);

        send_word(16'hA5A5, 1'b0, 1'b0, 0);
        send_word(16'h5A5A, 1'b0, 1'b0, 170);

        for (int n = 0; n < 3000; n++) begin
            valid_r = ($urandom_range(0, 3) != 0);
            data_r  = W'($urandom);
            pf_r    = 1'($urandom_range(0, 1));
            err_r   = ($urandom_range(0, 3) == 0);
            step();
        end
        valid_r = 1'b0;
        repeat (180) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
